dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-back, write-allocate data cache between the CPU's data-memory port and the block-wide data memory. It presents the CPU-side byte interface the CPU already drives (read/write/address/writedata/readdata/busywait) and issues 32-bit block transfers to data memory, stalling the CPU via `cpu_busywait` on misses. Geometry: 8 blocks × 4 bytes (32 B) over an 8-bit byte address space.

## Interface
- `STATS_W`, 16, width of the optional statistics counters.

- `CLK` in 1: sole clock; all state updates on posedge.
- `RESET` in 1: synchronous, active-high.
- `cpu_read` in 1: CPU load request.
- `cpu_write` in 1: CPU store request.
- `cpu_address` in 8: byte address; tag [7:5], index [4:2], offset [1:0].
- `cpu_writedata` in 8: store byte.
- `cpu_readdata` out 8: load byte.
- `cpu_busywait` out 1: CPU must hold its request and stall while high.
- `mem_read` out 1: block read request.
- `mem_write` out 1: block write request.
- `mem_address` out 6: block address {tag, index}.
- `mem_writedata` out 32: victim block; byte 0 in [7:0].
- `mem_readdata` in 32: fill block; byte 0 in [7:0].
- `mem_busywait` in 1: memory busy.
- `hit_count`, `miss_count`, `wb_count` out `STATS_W`: only with `DCACHE_STATS_EN`.

## Operation
- Per block: valid, dirty, 3-bit tag, 32-bit data.
- hit = valid[index] && tag[index] == cpu_address[7:5].
- `cpu_read` and `cpu_write` both high: treated as a write.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE, no request: `cpu_busywait` = 0.
- IDLE, read hit: `cpu_readdata` = selected byte (combinational); `cpu_busywait` = 0.
- IDLE, write hit: `cpu_busywait` = 0; byte written and dirty set at the posedge.
- IDLE, miss with victim clean or invalid: go to FETCH.
- IDLE, miss with victim valid and dirty: go to WRITEBACK.
- Any miss: `cpu_busywait` = 1 until the hit cycle.
- WRITEBACK: `mem_write` = 1; `mem_address` = {old tag, index}; `mem_writedata` = victim block. Go to FETCH on exit.
- FETCH: `mem_read` = 1; `mem_address` = {new tag, index}. Go to UPDATE on exit.
- Exit from WRITEBACK and FETCH: `mem_busywait` is ignored in the first cycle of the state. The state exits on the first later posedge with `mem_busywait` = 0.
- UPDATE: on the posedge, data = `mem_readdata`, tag = new tag, valid = 1, dirty = 0. Go to IDLE.
- Back in IDLE after a fill: the request now hits and is serviced as above. A store on a miss is therefore merged after the fill.
- `cpu_readdata` reads 8'h00 whenever the cycle is not an IDLE read hit.
- CPU must keep address/data stable while `cpu_busywait` = 1; the cache does not latch them.

## Timing
- Reset values: state IDLE; all valid and dirty bits 0; `mem_read`, `mem_write` 0; `mem_address` 0; `mem_writedata` 0; `cpu_readdata` 0; `cpu_busywait` 0 when there is no request; counters 0.
- Hit: 0 stall cycles.
- Clean miss: 1 + N FETCH cycles + 1 UPDATE cycle of stall, where N ≥ 1 is the number of cycles until `mem_busywait` drops.
- Dirty miss: adds the WRITEBACK cycles (≥ 2) before FETCH.
- `mem_read` and `mem_write` are never high together. Each is held constant for the whole state.
- `RESET` mid-miss: at that posedge the FSM returns to IDLE and all lines are invalidated (dirty data is discarded). `mem_read` and `mem_write` are low from the next cycle.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_count` increments in each IDLE cycle with a request that hits, excluding the post-UPDATE replay.
  - `miss_count` increments on each IDLE→WRITEBACK/FETCH transition.
  - `wb_count` increments on each WRITEBACK entry.
  - All counters saturate at all-ones.
- Undefined: the counter ports and logic are absent; behaviour is otherwise identical.

## Structure
- Package `dcache_pkg`: TAG_W=3, IDX_W=3, OFF_W=2, NUM_BLOCKS=8, BLOCK_W=32, and the state enum `dcache_state_t`.
- Sub-module `dcache_ctrl`: the FSM plus memory-handshake outputs. The top level holds the arrays, hit compare and byte select.

## Test plan
- Reset, then read 0x00: FETCH with `mem_address`=0x00. Memory returns 0x44332211 → `cpu_readdata`=0x11. Read 0x03 next → 0x44, `cpu_busywait`=0 with 0 stall cycles.
- Write 0xAA to 0x01 (hit after the fill above), then read 0x01 → 0xAA; no memory request is issued.
- Read 0x20 (same index 0, tag 1): WRITEBACK with `mem_address`=0x00 and `mem_writedata`=0x4433AA11, then FETCH with `mem_address`=0x08.
- Write 0x55 to 0xE7 (miss on a clean invalid line): FETCH only, then the byte is merged and the line is dirty. A later read of 0xC4 triggers a writeback to block 0x39.
- Memory holds `mem_busywait` high for 5 cycles during a FETCH: `cpu_busywait` stays high throughout, and `mem_read` stays stable and high.
- Assert `RESET` during FETCH: next cycle `mem_read`=0. A re-read of the same address misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared geometry constants and FSM state type for the data cache.
// Imported by dcache_ctrl and the dcache top level.
package dcache_pkg;

    localparam int TAG_W      = 3;
    localparam int IDX_W      = 3;
    localparam int OFF_W      = 2;
    localparam int NUM_BLOCKS = 8;
    localparam int BLOCK_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } dcache_state_t;

endpackage

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM of the data cache with registered memory handshake.
// Ports: clk_i/rst_i, request/hit/victim info from the arrays,
//        mem_busywait_i, state_o, mem_read_o/mem_write_o/mem_address_o/
//        mem_writedata_o, and with DCACHE_STATS_EN the statistics counters.
module dcache_ctrl
    import dcache_pkg::*;
`ifdef DCACHE_STATS_EN
#(
    parameter int STATS_W = 16
)
`endif
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic                     hit_i,
    input  logic                     victim_dirty_i,
    input  logic [TAG_W-1:0]         old_tag_i,
    input  logic [TAG_W-1:0]         new_tag_i,
    input  logic [IDX_W-1:0]         index_i,
    input  logic [BLOCK_W-1:0]       victim_i,
    input  logic                     mem_busywait_i,
    output dcache_state_t            state_o,
    output logic                     mem_read_o,
    output logic                     mem_write_o,
    output logic [TAG_W+IDX_W-1:0]   mem_address_o,
    output logic [BLOCK_W-1:0]       mem_writedata_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [STATS_W-1:0]       hit_count_o,
    output logic [STATS_W-1:0]       miss_count_o,
    output logic [STATS_W-1:0]       wb_count_o
`endif
);

    dcache_state_t              state_q;
    logic                       first_q;
    logic                       mem_read_q;
    logic                       mem_write_q;
    logic [TAG_W+IDX_W-1:0]     mem_address_q;
    logic [BLOCK_W-1:0]         mem_writedata_q;

    // first_q marks the first cycle of WRITEBACK/FETCH, where the
    // memory has not yet had a chance to raise its busywait.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            first_q         <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            first_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_i && !hit_i) begin
                        first_q <= 1'b1;
                        if (victim_dirty_i) begin
                            state_q         <= WRITEBACK;
                            mem_write_q     <= 1'b1;
                            mem_address_q   <= {old_tag_i, index_i};
                            mem_writedata_q <= victim_i;
                        end else begin
                            state_q       <= FETCH;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= {new_tag_i, index_i};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!first_q && !mem_busywait_i) begin
                        state_q         <= FETCH;
                        first_q         <= 1'b1;
                        mem_write_q     <= 1'b0;
                        mem_writedata_q <= '0;
                        mem_read_q      <= 1'b1;
                        mem_address_q   <= {new_tag_i, index_i};
                    end
                end
                FETCH: begin
                    if (!first_q && !mem_busywait_i) begin
                        state_q       <= UPDATE;
                        mem_read_q    <= 1'b0;
                        mem_address_q <= '0;
                    end
                end
                UPDATE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o         = state_q;
    assign mem_read_o      = mem_read_q;
    assign mem_write_o     = mem_write_q;
    assign mem_address_o   = mem_address_q;
    assign mem_writedata_o = mem_writedata_q;

`ifdef DCACHE_STATS_EN
    logic               replay_q;
    logic [STATS_W-1:0] hit_q;
    logic [STATS_W-1:0] miss_q;
    logic [STATS_W-1:0] wb_q;

    // replay_q flags the IDLE cycle right after a fill, whose hit is
    // the completion of an already counted miss.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            replay_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
            wb_q     <= '0;
        end else begin
            replay_q <= (state_q == UPDATE);
            if (state_q == IDLE && req_i) begin
                if (hit_i && !replay_q && hit_q != '1)
                    hit_q <= hit_q + 1'b1;
                if (!hit_i && miss_q != '1)
                    miss_q <= miss_q + 1'b1;
                if (!hit_i && victim_dirty_i && wb_q != '1)
                    wb_q <= wb_q + 1'b1;
            end
        end
    end

    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;
    assign wb_count_o   = wb_q;
`endif

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back write-allocate data cache, 8 x 4-byte blocks.
// Ports: CLK, RESET, cpu_read/cpu_write/cpu_address/cpu_writedata,
//        cpu_readdata/cpu_busywait, mem_read/mem_write/mem_address/
//        mem_writedata, mem_readdata/mem_busywait.
// Option: DCACHE_STATS_EN adds hit_count/miss_count/wb_count (STATS_W).
module dcache
    import dcache_pkg::*;
`ifdef DCACHE_STATS_EN
#(
    parameter int STATS_W = 16
)
`endif
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_address,
    input  logic [7:0]  cpu_writedata,
    output logic [7:0]  cpu_readdata,
    output logic        cpu_busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [STATS_W-1:0] hit_count,
    output logic [STATS_W-1:0] miss_count,
    output logic [STATS_W-1:0] wb_count
`endif
);

    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic             req;
    logic             hit;
    logic             is_idle;
    dcache_state_t    state;

    assign tag     = cpu_address[7:5];
    assign idx     = cpu_address[4:2];
    assign off     = cpu_address[1:0];
    assign req     = cpu_read | cpu_write;
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign is_idle = (state == IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state == UPDATE) begin
            data_q[idx]  <= mem_readdata;
            tag_q[idx]   <= tag;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (is_idle && cpu_write && hit) begin
            data_q[idx][{off, 3'b000} +: 8] <= cpu_writedata;
            dirty_q[idx] <= 1'b1;
        end
    end

    // A simultaneous read and write is treated as a write.
    assign cpu_readdata = (is_idle && cpu_read && !cpu_write && hit)
                        ? data_q[idx][{off, 3'b000} +: 8] : 8'h00;
    assign cpu_busywait = req && !(is_idle && hit);

    dcache_ctrl u_ctrl (
        .clk_i           (CLK),
        .rst_i           (RESET),
        .req_i           (req),
        .hit_i           (hit),
        .victim_dirty_i  (valid_q[idx] & dirty_q[idx]),
        .old_tag_i       (tag_q[idx]),
        .new_tag_i       (tag),
        .index_i         (idx),
        .victim_i        (data_q[idx]),
        .mem_busywait_i  (mem_busywait),
        .state_o         (state),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .mem_address_o   (mem_address),
        .mem_writedata_o (mem_writedata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count_o     (hit_count),
        .miss_count_o    (miss_count),
        .wb_count_o      (wb_count)
`endif
    );

endmodule

// File: tb/tb_dcache.sv
// Directed scoreboard bench for dcache with a latency-programmable
// block memory model.
module tb_dcache;

    logic        CLK;
    logic        RESET;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_address;
    logic [7:0]  cpu_writedata;
    logic [7:0]  cpu_readdata;
    logic        cpu_busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic [15:0] wb_count;
`endif

    dcache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .cpu_busywait  (cpu_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count),
        .wb_count      (wb_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          wr;
        logic [5:0]  a;
        logic [31:0] d;
    } mtx_t;

    mtx_t        exp_mem[$];
    logic [7:0]  exp_rd[$];
    logic [31:0] mem [64];
    int          n_chk;
    int          n_fail;
    int          n_txn;
    int          lat;
    int          m_cnt;
    bit          m_rd;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic mtx_t mk(input bit wr, input logic [5:0] a,
                                input logic [31:0] d);
        mtx_t t;
        t.wr = wr;
        t.a  = a;
        t.d  = d;
        return t;
    endfunction

    // Block memory: raises busywait half a cycle after seeing a request,
    // holds it for lat cycles, and keeps readdata stable afterwards.
    always @(negedge CLK) begin
        if (RESET) begin
            m_cnt        = 0;
            mem_busywait <= 1'b0;
        end else if (m_cnt != 0) begin
            check("mem_rd_hold", mem_read, m_rd);
            check("mem_wr_hold", mem_write, !m_rd);
            check("mem_addr_hold", mem_address, m_addr);
            check("cpu_busy_hold", cpu_busywait, 1);
            m_cnt--;
            if (m_cnt == 0) begin
                if (m_rd) mem_readdata <= mem[m_addr];
                else mem[m_addr] = m_wdata;
                mem_busywait <= 1'b0;
            end
        end else if (mem_read || mem_write) begin
            check("mem_excl", mem_read & mem_write, 0);
            n_txn++;
            m_rd    = mem_read;
            m_addr  = mem_address;
            m_wdata = mem_writedata;
            if (exp_mem.size() == 0) begin
                check("mem_unexpected", 1, 0);
            end else begin
                mtx_t e;
                e = exp_mem.pop_front();
                check("mem_kind", mem_write, e.wr);
                check("mem_addr", mem_address, e.a);
                if (e.wr) check("mem_wdata", mem_writedata, e.d);
            end
            m_cnt        = lat;
            mem_busywait <= 1'b1;
        end
    end

    task automatic cpu_op(input bit w, input logic [7:0] a,
                          input logic [7:0] d, output int stall);
        stall = 0;
        @(negedge CLK);
        cpu_read      = !w;
        cpu_write     = w;
        cpu_address   = a;
        cpu_writedata = d;
        #1;
        while (cpu_busywait === 1'b1 && stall < 100) begin
            check("rd_zero_busy", cpu_readdata, 0);
            @(negedge CLK);
            #1;
            stall++;
        end
        if (stall >= 100) check("timeout", 1, 0);
        if (!w) begin
            if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
            else check("rdata", cpu_readdata, exp_rd.pop_front());
        end
        @(posedge CLK);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        int          st;
        int          t0;
        logic [31:0] m39;
        logic [31:0] wbd;
        n_chk  = 0;
        n_fail = 0;
        n_txn  = 0;
        lat    = 1;
        m_cnt  = 0;
        RESET         = 1'b1;
        cpu_read      = 1'b0;
        cpu_write     = 1'b0;
        cpu_address   = 8'h00;
        cpu_writedata = 8'h00;
        mem_busywait  = 1'b0;
        mem_readdata  = 32'h0;
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b;
            b = 8'(i);
            mem[i] = {b + 8'h30, b + 8'h20, b + 8'h10, b};
        end
        mem[0] = 32'h44332211;
        m39    = mem[6'h39];

        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", cpu_busywait, 0);
        check("rst_mrd", mem_read, 0);
        check("rst_mwr", mem_write, 0);
        check("rst_maddr", mem_address, 0);
        check("rst_mwdata", mem_writedata, 0);
        check("rst_rdata", cpu_readdata, 0);
        @(negedge CLK);
        RESET = 1'b0;

        exp_mem.push_back(mk(0, 6'h00, 0));
        exp_rd.push_back(8'h11);
        cpu_op(0, 8'h00, 8'h00, st);
        check("miss_stall", st > 0, 1);

        exp_rd.push_back(8'h44);
        cpu_op(0, 8'h03, 8'h00, st);
        check("hit_stall", st, 0);

        t0 = n_txn;
        cpu_op(1, 8'h01, 8'hAA, st);
        check("whit_stall", st, 0);
        exp_rd.push_back(8'hAA);
        cpu_op(0, 8'h01, 8'h00, st);
        check("rhit_stall", st, 0);
        check("no_mem_txn", n_txn, t0);

        exp_mem.push_back(mk(1, 6'h00, 32'h4433AA11));
        exp_mem.push_back(mk(0, 6'h08, 0));
        exp_rd.push_back(mem[6'h08][7:0]);
        cpu_op(0, 8'h20, 8'h00, st);
        check("wb_miss_stall", st > 0, 1);
        check("wb_mem_value", mem[6'h00], 32'h4433AA11);

        exp_mem.push_back(mk(0, 6'h39, 0));
        cpu_op(1, 8'hE7, 8'h55, st);
        check("wmiss_stall", st > 0, 1);
        exp_rd.push_back(8'h55);
        cpu_op(0, 8'hE7, 8'h00, st);
        check("merge_hit", st, 0);

        wbd = {8'h55, m39[23:0]};
        exp_mem.push_back(mk(1, 6'h39, wbd));
        exp_mem.push_back(mk(0, 6'h31, 0));
        exp_rd.push_back(mem[6'h31][7:0]);
        cpu_op(0, 8'hC4, 8'h00, st);
        check("dirty_wb_stall", st > 0, 1);

        lat = 5;
        exp_mem.push_back(mk(0, 6'h10, 0));
        exp_rd.push_back(mem[6'h10][7:0]);
        cpu_op(0, 8'h40, 8'h00, st);
        check("slow_stall", st >= 5, 1);

`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, 4);
        check("miss_count", miss_count, 5);
        check("wb_count", wb_count, 2);
`endif

        lat = 3;
        exp_mem.push_back(mk(0, 6'h09, 0));
        @(negedge CLK);
        cpu_read    = 1'b1;
        cpu_address = 8'h24;
        for (int i = 0; i < 20 && mem_read !== 1'b1; i++)
            @(negedge CLK);
        check("rst_fetch_seen", mem_read, 1);
        @(negedge CLK);
        cpu_read = 1'b0;
        RESET    = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_mid_mrd", mem_read, 0);
        check("rst_mid_mwr", mem_write, 0);
        check("rst_mid_busy", cpu_busywait, 0);
        @(negedge CLK);
        #1;
        RESET = 1'b0;

        lat = 1;
        t0  = n_txn;
        exp_mem.push_back(mk(0, 6'h09, 0));
        exp_rd.push_back(mem[6'h09][7:0]);
        cpu_op(0, 8'h24, 8'h00, st);
        check("rerd_miss", st > 0, 1);
        check("rerd_txn", n_txn, t0 + 1);

`ifdef DCACHE_STATS_EN
        check("hit_after_rst", hit_count, 0);
        check("miss_after_rst", miss_count, 1);
        check("wb_after_rst", wb_count, 0);
`endif

        repeat (2) @(negedge CLK);
        check("mem_q_empty", exp_mem.size(), 0);
        check("rd_q_empty", exp_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
